adc_stream_packer: RTL and testbench

Downstream consumer of the AXI-Lite control register's data_en bit. Captures deinterleaved two-channel AD9643 samples, 14 bits per channel, while capture is enabled. Packs each channel pair into one 32-bit word, buffers it in a small FWFT FIFO, and emits fixed-length AXI4-Stream frames with tlast toward the DMA. Frame boundaries are always respected on start/stop; FIFO overflow drops samples and is counted.

---
 rtl/adc_stream_packer.sv | 150 +++++++++++++++
 tb/tb_adc_stream_packer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_stream_packer.sv
// Packs two-channel AD9643 samples into 32-bit words and frames them as fixed-length AXI4-Stream packets.
// Optional build macro ADC_TEST_PATTERN_EN replaces the ADC inputs with an internal ramp pattern.
module adc_stream_packer #(
    parameter int PACKET_LEN = 256,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_aresetn,
    input  logic                 data_en,
    input  logic                 adc_valid,
    input  logic [13:0]          adc_data_a,
    input  logic [13:0]          adc_data_b,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 busy
);

    localparam int BW = $clog2(PACKET_LEN);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PACKET_LEN - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic signed [15:0] sext16(input logic signed [13:0] x);
        return {{2{x[13]}}, x};
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    state_t                state;
    logic [BW-1:0]         beat;
    logic [BW-1:0]         beat_nxt;
    logic                  beat_last;
    logic                  capturing;
    logic                  wr_en;
    logic                  rd_en;
    logic                  drop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [32:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic signed [13:0]    smp_a;
    logic signed [13:0]    smp_b;
    logic [31:0]           word;

`ifdef ADC_TEST_PATTERN_EN
    logic [13:0] ramp;

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            ramp <= '0;
        end else if (state == IDLE && data_en) begin
            ramp <= '0;
        end else if (wr_en) begin
            ramp <= ramp + 1'b1;
        end
    end

    assign smp_a = ramp;
    assign smp_b = ~ramp;
`else
    assign smp_a = adc_data_a;
    assign smp_b = adc_data_b;
`endif

    assign word       = {sext16(smp_b), sext16(smp_a)};
    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign capturing  = (state == RUN) || (state == DRAIN);
    // Full is judged on current occupancy; a pop in the same cycle does not make room.
    assign wr_en      = capturing && adc_valid && !fifo_full;
    assign drop       = capturing && adc_valid && fifo_full;
    assign rd_en      = !fifo_empty && m_axis_tready;
    assign beat_last  = (beat == LAST_BEAT);
    assign beat_nxt   = !wr_en ? beat : (beat_last ? '0 : beat + 1'b1);

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state      <= IDLE;
            beat       <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_en) begin
                        state      <= RUN;
                        beat       <= '0;
                        overflow   <= 1'b0;
                        drop_count <= '0;
                    end
                end
                RUN: begin
                    beat <= beat_nxt;
                    // Leaving on a frame boundary skips DRAIN entirely.
                    if (!data_en) begin
                        state <= (beat_nxt == '0) ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    beat <= beat_nxt;
                    if (wr_en && beat_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage boundary: data only, no reset.
    always_ff @(posedge s_axi_aclk) begin
        if (wr_en) mem[wr_ptr] <= {beat_last, word};
    end

    assign m_axis_tvalid                 = !fifo_empty;
    assign {m_axis_tlast, m_axis_tdata}  = fifo_empty ? 33'd0 : mem[rd_ptr];
    assign busy                          = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_adc_stream_packer.sv
// Directed self-checking bench for adc_stream_packer with PACKET_LEN=8, FIFO_DEPTH=16.
module tb_adc_stream_packer;

    localparam int PL = 8;
    localparam int FD = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          data_en;
    logic          adc_valid;
    logic [13:0]   a;
    logic [13:0]   b;
    logic [31:0]   tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          overflow;
    logic [CW-1:0] drop_count;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
`ifdef ADC_TEST_PATTERN_EN
    logic [13:0] ramp_m;
`endif

    always #5 clk = ~clk;

    adc_stream_packer #(.PACKET_LEN(PL), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn), .data_en(data_en), .adc_valid(adc_valid),
        .adc_data_a(a), .adc_data_b(b), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast), .overflow(overflow),
        .drop_count(drop_count), .busy(busy)
    );

    // Expected word for the next accepted sample, in acceptance order.
    function automatic logic [31:0] exp_word(input logic [13:0] sa, input logic [13:0] sb);
`ifdef ADC_TEST_PATTERN_EN
        logic [13:0] r;
        r = ramp_m;
        ramp_m = ramp_m + 14'd1;
        return {{2{~r[13]}}, ~r, {2{r[13]}}, r};
`else
        return {{2{sb[13]}}, sb, {2{sa[13]}}, sa};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0; data_en = 1'b0; adc_valid = 1'b0; tready = 1'b0;
        a = '0; b = '0;
        step();
        step();
        aresetn = 1'b1;
        exp_q.delete();
    endtask

    task automatic start_capture();
        data_en = 1'b1;
        adc_valid = 1'b0;
`ifdef ADC_TEST_PATTERN_EN
        ramp_m = '0;
`endif
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
        checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", tlast); end
        checks++; if (tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", tdata); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (drop_count !== '0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_stream();
        logic [31:0] ew;
        do_reset();
        tready = 1'b1; a = 14'h1FFF; b = 14'h2000;
        start_capture();
        checks++; if (busy !== 1'b1 || tvalid !== 1'b0) begin
            errors++; $display("FAIL stream_run_entry: busy=%b tvalid=%b expected busy=1 tvalid=0", busy, tvalid);
        end
        adc_valid = 1'b1;
        step();
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL stream_first_valid: got %b expected 1", tvalid); end
        for (int n = 0; n < 3 * PL; n++) begin
            ew = exp_word(a, b);
            checks++;
            if (tvalid !== 1'b1 || tdata !== ew || tlast !== ((n % PL) == PL - 1)) begin
                errors++;
                $display("FAIL stream_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         n, tvalid, tdata, tlast, ew, ((n % PL) == PL - 1));
            end
            step();
        end
    endtask

    task automatic test_drain();
        int pops = 0;
        logic [32:0] e;
        do_reset();
        tready = 1'b1;
        start_capture();
        for (int c = 0; c < 20; c++) begin
            adc_valid = 1'b1;
            a = 14'(100 + c);
            b = 14'h3FFF - 14'(c);
            data_en = (c < 3);
            if (c < PL) exp_q.push_back({c == PL - 1, exp_word(a, b)});
            if (c == 8) begin
                checks++; if (busy !== 1'b1 || tvalid !== 1'b1) begin
                    errors++; $display("FAIL drain_busy_before_pop: busy=%b tvalid=%b expected 1 1", busy, tvalid);
                end
            end
            if (c == 9) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy_after_pop: got %b expected 0", busy); end
            end
            if (tvalid && tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL drain_extra_beat: got %h expected no beat", tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({tlast, tdata} !== e) begin
                        errors++; $display("FAIL drain_beat%0d: got %h expected %h", pops, {tlast, tdata}, e);
                    end
                end
                pops++;
            end
            step();
        end
        checks++; if (pops != PL) begin errors++; $display("FAIL drain_pop_count: got %0d expected %0d", pops, PL); end
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL drain_final_tvalid: got %b expected 0", tvalid); end
    endtask

    task automatic test_overflow();
        int pops = 0;
        logic [32:0] e;
        do_reset();
        tready = 1'b0;
        start_capture();
        for (int c = 0; c < 20; c++) begin
            adc_valid = 1'b1;
            a = 14'(c * 3);
            b = 14'h2000 + 14'(c);
            if (c < FD) exp_q.push_back({(c % PL) == PL - 1, exp_word(a, b)});
            step();
        end
        adc_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL ovf_drop_count: got %0d expected 4", drop_count); end
        checks++; if (tvalid !== 1'b1 || {tlast, tdata} !== exp_q[0]) begin
            errors++; $display("FAIL ovf_head_hold: got %h expected %h", {tlast, tdata}, exp_q[0]);
        end
        data_en = 1'b0;
        step();
        tready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (tvalid && tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL ovf_extra_beat: got %h expected no beat", tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({tlast, tdata} !== e) begin
                        errors++; $display("FAIL ovf_beat%0d: got %h expected %h", pops, {tlast, tdata}, e);
                    end
                end
                pops++;
            end
            step();
        end
        checks++; if (pops != FD) begin errors++; $display("FAIL ovf_pop_count: got %0d expected %0d", pops, FD); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky_idle: got %b expected 1", overflow); end
        data_en = 1'b1;
        step();
        checks++; if (overflow !== 1'b0 || drop_count !== '0) begin
            errors++; $display("FAIL ovf_clear_on_start: got ovf=%b cnt=%0d expected 0 0", overflow, drop_count);
        end
    endtask

    task automatic test_reset_midframe();
        int pops = 0;
        int first_last = -1;
        logic [32:0] e;
        do_reset();
        tready = 1'b0;
        start_capture();
        for (int c = 0; c < 3; c++) begin
            adc_valid = 1'b1; a = 14'(c + 7); b = 14'(c + 9);
            step();
        end
        adc_valid = 1'b0;
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_valid: got %b expected 1", tvalid); end
        aresetn = 1'b0; data_en = 1'b0;
        step();
        checks++; if (tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs: got v=%b l=%b busy=%b expected 0 0 0", tvalid, tlast, busy);
        end
        aresetn = 1'b1;
        exp_q.delete();
        tready = 1'b1;
        start_capture();
        for (int c = 0; c < 20; c++) begin
            adc_valid = 1'b1; a = 14'(200 + c); b = 14'(c);
            exp_q.push_back({(c % PL) == PL - 1, exp_word(a, b)});
            if (tvalid && tready) begin
                checks++;
                e = exp_q.pop_front();
                if ({tlast, tdata} !== e) begin
                    errors++; $display("FAIL rst_mid_beat%0d: got %h expected %h", pops, {tlast, tdata}, e);
                end
                pops++;
                if (tlast && first_last < 0) first_last = pops;
            end
            step();
        end
        checks++; if (first_last != PL) begin
            errors++; $display("FAIL rst_mid_first_tlast: got beat %0d expected %0d", first_last, PL);
        end
    endtask

    task automatic test_toggle();
        int pops = 0;
        int k = 0;
        logic [15:0] rdy_pat;
        logic prev_stall;
        logic [32:0] prev_word;
        logic [32:0] e;
        do_reset();
        start_capture();
        rdy_pat = 16'b1011_0011_1000_1101;
        prev_stall = 1'b0;
        prev_word = '0;
        for (int c = 0; c < 48; c++) begin
            adc_valid = (c < 16) && (c % 2 == 0);
            data_en = (c < 16);
            tready = (c < 16) ? rdy_pat[c] : 1'b1;
            if (adc_valid) begin
                a = 14'(50 + c); b = 14'h1000 ^ 14'(c);
                exp_q.push_back({k == PL - 1, exp_word(a, b)});
                k++;
            end else begin
                a = 14'h2AAA; b = 14'h1555;
            end
            if (prev_stall) begin
                checks++;
                if (tvalid !== 1'b1 || {tlast, tdata} !== prev_word) begin
                    errors++; $display("FAIL toggle_head_stable: got v=%b %h expected v=1 %h", tvalid, {tlast, tdata}, prev_word);
                end
            end
            if (tvalid && tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL toggle_extra_beat: got %h expected no beat", tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({tlast, tdata} !== e) begin
                        errors++; $display("FAIL toggle_beat%0d: got %h expected %h", pops, {tlast, tdata}, e);
                    end
                end
                pops++;
            end
            prev_stall = tvalid && !tready;
            prev_word = {tlast, tdata};
            step();
        end
        checks++; if (pops != PL) begin errors++; $display("FAIL toggle_pop_count: got %0d expected %0d", pops, PL); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL toggle_final_busy: got %b expected 0", busy); end
    endtask

`ifdef ADC_TEST_PATTERN_EN
    task automatic test_pattern();
        do_reset();
        tready = 1'b0;
        start_capture();
        adc_valid = 1'b1; a = 14'h1234; b = 14'h0567;
        step(); step(); step();
        adc_valid = 1'b0;
        checks++; if (tdata !== 32'hFFFF0000) begin errors++; $display("FAIL pattern_beat0: got %h expected FFFF0000", tdata); end
        tready = 1'b1;
        step();
        checks++; if (tdata !== 32'hFFFE0001) begin errors++; $display("FAIL pattern_beat1: got %h expected FFFE0001", tdata); end
        step();
        checks++; if (tdata !== 32'hFFFD0002) begin errors++; $display("FAIL pattern_beat2: got %h expected FFFD0002", tdata); end
    endtask
`endif

    initial begin
        aresetn = 1'b0; data_en = 1'b0; adc_valid = 1'b0; tready = 1'b0;
        a = '0; b = '0;
        test_reset();
        test_stream();
        test_drain();
        test_overflow();
        test_reset_midframe();
        test_toggle();
`ifdef ADC_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
